// File: rtl/mvd_pingpong_buf_pkg.sv
// mvd_pingpong_buf shared defaults and types.
// Build option: MVD_BUF_OREG_EN adds an output register stage.
package mvd_pingpong_buf_pkg;

  localparam int MVD_DATA_WIDTH = 18;
  localparam int MVD_ADDR_WIDTH = 5;

  typedef struct packed {
    logic wr;
    logic wd;
    logic rd;
    logic rdn;
  } acc_t;

endpackage

// File: rtl/mvd_pingpong_buf_if.sv
// mvd -> buffer -> ec handshake bundle.
// master = mvd/ec side, slave = buffer.
interface mvd_pingpong_buf_if
  import mvd_pingpong_buf_pkg::*;
#(
  parameter int DATA_WIDTH = MVD_DATA_WIDTH,
  parameter int ADDR_WIDTH = MVD_ADDR_WIDTH
);
  logic                  wr_i;
  logic [ADDR_WIDTH-1:0] w_addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  w_done_i;
  logic                  w_full_o;
  logic                  r_valid_o;
  logic                  rd_i;
  logic [ADDR_WIDTH-1:0] r_addr_i;
  logic                  r_done_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rd_vld_o;
  logic                  err_o;

  modport master (
    output wr_i, w_addr_i, data_i, w_done_i,
    output rd_i, r_addr_i, r_done_i,
    input  w_full_o, r_valid_o, data_o,
    input  rd_vld_o, err_o
  );

  modport slave (
    input  wr_i, w_addr_i, data_i, w_done_i,
    input  rd_i, r_addr_i, r_done_i,
    output w_full_o, r_valid_o, data_o,
    output rd_vld_o, err_o
  );
endinterface

// File: rtl/mvd_pingpong_buf_rf_2p.sv
// Two-port register file: port A sync read, port B write.
// Enables are active-low; contents are never reset.
module mvd_pingpong_buf_rf_2p #(
  parameter int Addr_Width = 6,
  parameter int Word_Width = 18
) (
  input  logic                  clk,
  input  logic                  cena,
  input  logic [Addr_Width-1:0] aa,
  output logic [Word_Width-1:0] qa,
  input  logic                  cenb,
  input  logic                  wenb,
  input  logic [Addr_Width-1:0] ab,
  input  logic [Word_Width-1:0] db
);

  logic [Word_Width-1:0] mem [1<<Addr_Width];

  always_ff @(posedge clk) begin
    if (!cenb && !wenb) mem[ab] <= db;
  end

  always_ff @(posedge clk) begin
    if (!cena) qa <= mem[aa];
  end

endmodule

// File: rtl/mvd_pingpong_buf.sv
// Ping-pong mvd buffer with full/empty tracking and sticky error.
// Define MVD_BUF_OREG_EN for a registered data_o (latency 2).
module mvd_pingpong_buf
  import mvd_pingpong_buf_pkg::*;
#(
  parameter int DATA_WIDTH = MVD_DATA_WIDTH,
  parameter int ADDR_WIDTH = MVD_ADDR_WIDTH
) (
  input logic              clk,
  input logic              rst,
  mvd_pingpong_buf_if.slave bus
);

  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            full;
  logic [1:0]            full_nx;
  logic                  err;
  logic                  bad;
  logic                  vld1;
  logic [DATA_WIDTH-1:0] q;
  acc_t                  ok;

  always_comb begin
    ok.wr  = bus.wr_i     & ~full[wr_bank];
    ok.wd  = bus.w_done_i & ~full[wr_bank];
    ok.rd  = bus.rd_i     &  full[rd_bank];
    ok.rdn = bus.r_done_i &  full[rd_bank];
    bad = ((bus.wr_i | bus.w_done_i) &  full[wr_bank])
        | ((bus.rd_i | bus.r_done_i) & ~full[rd_bank]);
  end

  // Same-bank set/clear are mutually exclusive by construction
  always_comb begin
    full_nx = full;
    if (ok.wd)  full_nx[wr_bank] = 1'b1;
    if (ok.rdn) full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      err     <= 1'b0;
      vld1    <= 1'b0;
    end else begin
      wr_bank <= wr_bank ^ ok.wd;
      rd_bank <= rd_bank ^ ok.rdn;
      full    <= full_nx;
      err     <= err | bad;
      vld1    <= ok.rd;
    end
  end

  mvd_pingpong_buf_rf_2p #(
    .Addr_Width(ADDR_WIDTH+1),
    .Word_Width(DATA_WIDTH)
  ) u_rf (
    .clk  (clk),
    .cena (~ok.rd),
    .aa   ({rd_bank, bus.r_addr_i}),
    .qa   (q),
    .cenb (~ok.wr),
    .wenb (~ok.wr),
    .ab   ({wr_bank, bus.w_addr_i}),
    .db   (bus.data_i)
  );

  assign bus.w_full_o  = full[wr_bank];
  assign bus.r_valid_o = full[rd_bank];
  assign bus.err_o     = err;

`ifdef MVD_BUF_OREG_EN
  logic                  vld2;
  logic [DATA_WIDTH-1:0] dq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld2 <= 1'b0;
      dq   <= '0;
    end else begin
      vld2 <= vld1;
      if (vld1) dq <= q;
    end
  end

  assign bus.data_o   = dq;
  assign bus.rd_vld_o = vld2;
`else
  assign bus.data_o   = q;
  assign bus.rd_vld_o = vld1;
`endif

endmodule

// File: tb/tb_mvd_pingpong_buf.sv
// Bench for mvd_pingpong_buf: directed ping-pong plus random
// traffic against a bank/queue level reference model.
module tb_mvd_pingpong_buf;

`ifdef MVD_BUF_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mvd_pingpong_buf_if #(.DATA_WIDTH(18), .ADDR_WIDTH(5)) bus();

  mvd_pingpong_buf #(.DATA_WIDTH(18), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [17:0] mem [2][32];
  bit          full_m [2];
  bit          wb, rb, err_m;
  bit          sh_v [2];
  logic [17:0] sh_d [2];
  bit          exp_v;
  logic [17:0] exp_d;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(string tag);
    chk({tag, ".w_full"},  {31'd0, bus.w_full_o},  {31'd0, full_m[wb]});
    chk({tag, ".r_valid"}, {31'd0, bus.r_valid_o}, {31'd0, full_m[rb]});
    chk({tag, ".rd_vld"},  {31'd0, bus.rd_vld_o},  {31'd0, exp_v});
    chk({tag, ".err"},     {31'd0, bus.err_o},     {31'd0, err_m});
`ifdef MVD_BUF_OREG_EN
    chk({tag, ".data"}, {14'd0, bus.data_o}, {14'd0, exp_d});
`else
    if (exp_v) chk({tag, ".data"}, {14'd0, bus.data_o}, {14'd0, exp_d});
`endif
  endtask

  task automatic drive_idle();
    bus.wr_i = 0; bus.w_addr_i = '0; bus.data_i = '0;
    bus.w_done_i = 0; bus.rd_i = 0; bus.r_addr_i = '0;
    bus.r_done_i = 0;
  endtask

  task automatic model_reset();
    full_m[0] = 0; full_m[1] = 0;
    wb = 0; rb = 0; err_m = 0;
    sh_v[0] = 0; sh_v[1] = 0;
    exp_v = 0; exp_d = '0;
  endtask

  // one clock: drive at negedge, update model at posedge, check at negedge
  task automatic step(input bit wr, input bit [4:0] wa,
                      input bit [17:0] d, input bit wd,
                      input bit rd, input bit [4:0] ra,
                      input bit rdn, input string tag);
    bit wok, wdok, rok, rdnok;
    bus.wr_i = wr; bus.w_addr_i = wa; bus.data_i = d;
    bus.w_done_i = wd; bus.rd_i = rd; bus.r_addr_i = ra;
    bus.r_done_i = rdn;
    @(posedge clk);
    wok   = wr  && !full_m[wb];
    wdok  = wd  && !full_m[wb];
    rok   = rd  &&  full_m[rb];
    rdnok = rdn &&  full_m[rb];
    if ((wr || wd) && full_m[wb]) err_m = 1;
    if ((rd || rdn) && !full_m[rb]) err_m = 1;
    for (int i = LAT-1; i > 0; i--) begin
      sh_v[i] = sh_v[i-1];
      sh_d[i] = sh_d[i-1];
    end
    sh_v[0] = rok;
    sh_d[0] = mem[rb][ra];
    exp_v = sh_v[LAT-1];
    if (exp_v) exp_d = sh_d[LAT-1];
    if (wok) mem[wb][wa] = d;
    if (wdok) begin full_m[wb] = 1; wb = ~wb; end
    if (rdnok) begin full_m[rb] = 0; rb = ~rb; end
    @(negedge clk);
    chk_outs(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1;
    drive_idle();
    model_reset();
    #1;
    chk_outs("reset");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit [17:0] d;
    bit w, wd, r, rdn;
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    drive_idle();
    model_reset();
    #1;
    chk_outs("por");
    chk("por.rd_vld0", {31'd0, bus.rd_vld_o}, 32'd0);
    @(negedge clk);
    rst = 0;

    // underflow after reset
    step(0, 0, 0, 0, 1, 3, 1, "underflow");
    chk("underflow.err1", {31'd0, bus.err_o}, 32'd1);
    idle("underflow.hold");
    apply_reset();

    // basic fill of bank 0
    for (int i = 0; i < 32; i++)
      step(1, 5'(i), 18'(i), 0, 0, 0, 0, "fill0");
    chk("fill0.no_rvalid", {31'd0, bus.r_valid_o}, 32'd0);
    step(0, 0, 0, 1, 0, 0, 0, "wdone0");
    chk("wdone0.rvalid", {31'd0, bus.r_valid_o}, 32'd1);

    // drain bank 0 while filling bank 1
    for (int i = 0; i < 32; i++)
      step(1, 5'(i), 18'h3FFFF - 18'(i), 0, 1, 5'(i), 0, "overlap");
    idle("overlap.flush");
    if (LAT == 2) idle("overlap.flush2");

    // simultaneous done pulses
    step(0, 0, 0, 1, 0, 0, 1, "simul");
    chk("simul.w_full", {31'd0, bus.w_full_o}, 32'd0);
    chk("simul.r_valid", {31'd0, bus.r_valid_o}, 32'd1);
    chk("simul.err", {31'd0, bus.err_o}, 32'd0);

    // drain bank 1, refill bank 0 with random data
    for (int i = 0; i < 32; i++)
      step(1, 5'(i), 18'($urandom), 0, 1, 5'(i), 0, "drain1");
    step(0, 0, 0, 1, 0, 0, 0, "bothfull");
    chk("bothfull.w_full", {31'd0, bus.w_full_o}, 32'd1);

    // write while full: ignored, error set
    step(1, 5, 18'h12345, 0, 0, 0, 0, "bp.wr");
    chk("bp.err", {31'd0, bus.err_o}, 32'd1);
    step(0, 0, 0, 0, 1, 5, 0, "bp.rd");
    idle("bp.rdflush");
    if (LAT == 2) idle("bp.rdflush2");
    step(0, 0, 0, 0, 0, 0, 1, "bp.rdone");
    chk("bp.w_full_low", {31'd0, bus.w_full_o}, 32'd0);

    // reset in the middle of a read burst
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, 5'(i), 0, "midread");
    chk("midread.vld", {31'd0, bus.rd_vld_o}, 32'd1);
    apply_reset();
    for (int i = 0; i < 4; i++)
      step(1, 5'(i), 18'h2A000 + 18'(i), 0, 0, 0, 0, "refill");
    step(0, 0, 0, 1, 0, 0, 0, "refill.done");
    chk("refill.rvalid", {31'd0, bus.r_valid_o}, 32'd1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 5'(i), 0, "refill.rd");
    idle("refill.flush");
    idle("refill.flush2");

    // random legal traffic
    for (int n = 0; n < 2000; n++) begin
      w   = ($urandom % 2 == 0) && !full_m[wb];
      wd  = ($urandom % 8 == 0) && !full_m[wb];
      r   = ($urandom % 2 == 0) &&  full_m[rb];
      rdn = ($urandom % 8 == 0) &&  full_m[rb];
      d   = 18'($urandom);
      step(w, 5'($urandom), d, wd, r, 5'($urandom), rdn, "rnd_legal");
    end

    // random unconstrained traffic
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      w   = ($urandom % 2 == 0);
      wd  = ($urandom % 6 == 0);
      r   = ($urandom % 2 == 0);
      rdn = ($urandom % 6 == 0);
      d   = 18'($urandom);
      step(w, 5'($urandom), d, wd, r, 5'($urandom), rdn, "rnd_any");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mvd_pingpong_buf.md
# mvd_pingpong_buf

Parametrised, double-banked (ping-pong) motion-vector-difference buffer between the mvd module (producer) and the ec module (consumer). It generalises the fixed 18x32 two-port mvd RAM to configurable width and depth. It adds two banks with full/empty tracking and a done/valid handshake, so mvd can fill macroblock N+1 while ec drains macroblock N. It also has a sticky protocol-error flag and an optional output register stage.

## Interface
Parameters:
- DATA_WIDTH, 18, bits per mvd word
- ADDR_WIDTH, 5, per-bank address bits; bank depth = 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_i  in  1  write strobe, high active
- w_addr_i  in  ADDR_WIDTH  write address within current write bank
- data_i  in  DATA_WIDTH  write data
- w_done_i  in  1  one-cycle pulse: current write bank complete
- w_full_o  out  1  no free bank; producer must not write
- r_valid_o  out  1  current read bank holds a complete block
- rd_i  in  1  read strobe, high active
- r_addr_i  in  ADDR_WIDTH  read address within current read bank
- r_done_i  in  1  one-cycle pulse: current read bank consumed, release it
- data_o  out  DATA_WIDTH  read data
- rd_vld_o  out  1  data_o valid this cycle
- err_o  out  1  sticky protocol error

## Operation
- State: wr_bank (1b), rd_bank (1b), full[1:0] per bank.
- Storage is one 2-port array of 2*2^ADDR_WIDTH words. The physical address is {bank, addr}.
- Write: wr_i & ~full[wr_bank] writes data_i to {wr_bank, w_addr_i}.
- w_done_i & ~full[wr_bank]: set full[wr_bank] and toggle wr_bank.
- Read: rd_i & full[rd_bank] reads {rd_bank, r_addr_i}.
- r_done_i & full[rd_bank]: clear full[rd_bank] and toggle rd_bank.
- w_full_o = full[wr_bank]; r_valid_o = full[rd_bank]. Both are combinational from registers.
- Simultaneous w_done_i and r_done_i: both take effect in the same cycle. They touch different banks, or the same bank only when that bank is full (write side ignored) or empty (read side ignored).
- A wr_i or rd_i in the same cycle as its done pulse still targets the old bank. The toggle is visible from the next cycle.
- Read and write never address the same bank while both are legal, so no read-during-write forwarding is needed.
- Errors set err_o, which stays high until rst:
  - wr_i while w_full_o
  - w_done_i while w_full_o
  - rd_i while ~r_valid_o
  - r_done_i while ~r_valid_o
- An illegal access or pulse causes no state or array change.
- Reset mid-operation: both banks become empty, pointers return to 0, and in-flight reads are dropped (rd_vld_o 0). Array contents are not cleared and are undefined to the consumer.

## Timing
- Reset values:
  - wr_bank = rd_bank = 0, full = 00
  - w_full_o = 0, r_valid_o = 0, rd_vld_o = 0, err_o = 0
  - data_o = 0 with MVD_BUF_OREG_EN; undefined until first read without it
- Read latency: 1 cycle from rd_i to data_o/rd_vld_o without the macro; 2 cycles with it.
- Full reads are possible at one per cycle with back-to-back rd_i.
- Write takes effect at the rising edge where wr_i is sampled. The earliest legal read of that word follows w_done_i, one cycle after the r_valid_o rise.
- w_done_i to r_valid_o high: 1 cycle, when the read pointer is on that bank.
- r_done_i to w_full_o low: 1 cycle, when that bank was blocking the writer.

## Configuration
- MVD_BUF_OREG_EN defined:
  - adds a reset-to-0 register on data_o and a second delay stage on rd_vld_o
  - read latency 2; data_o holds its last value when rd_vld_o is 0
- Not defined: data_o comes straight from the array output register, read latency 1.

## Structure
- Shared enc_defines package/header holds:
  - MVD_DATA_WIDTH (18) and MVD_ADDR_WIDTH (5) defaults
  - macro MVD_BUF_OREG_EN
- Sub-module: the existing rf_2p primitive, instantiated with Addr_Width = ADDR_WIDTH+1 and Word_Width = DATA_WIDTH. Its low-active chip-enable and write-enable are driven from the legal-access terms.
- Control (pointers, full bits, error, latency pipe) stays in the top module.

## Test plan
- Basic ping-pong:
  - Write 32 words 0x00000..0x0001F to bank 0, then pulse w_done_i. Expect r_valid_o high one cycle later.
  - Read addr 0..31: data_o matches after 1 cycle (2 with macro), rd_vld_o high for 32 cycles.
- Overlap: while ec reads bank 0, mvd fills bank 1 with 0x3FFFF pattern. Both banks are intact, and after r_done_i r_valid_o stays high for bank 1.
- Backpressure:
  - Fill both banks. Expect w_full_o=1.
  - Issue wr_i: array unchanged, err_o=1.
  - r_done_i then clears w_full_o next cycle.
- Simultaneous pulses: with bank 0 full and bank 1 being written, assert w_done_i and r_done_i together. Expect full=10, wr_bank=0, rd_bank=1, no error.
- Underflow: rd_i and r_done_i after reset produce rd_vld_o=0 and err_o=1, with pointers unchanged.
- Reset mid-read: assert rst during a read burst. All outputs return to reset values asynchronously, and the next w_done_i restarts at bank 0.
